// File: rtl/alu_mp_sequencer.sv
// rtl/alu_mp_sequencer.sv - multi-slice sequencer driving a 74181-style ALU one word per cycle
// Latches a wide op, walks the slices LS-first chaining carry, and presents the wide result.
module alu_mp_sequencer #(
  parameter  int WORD_W    = 16,
  parameter  int NUM_WORDS = 4,
  localparam int OP_W      = WORD_W * NUM_WORDS,
  localparam int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [OP_W-1:0]   i_in_a,
  input  logic [OP_W-1:0]   i_in_b,
  input  logic [3:0]        i_in_select,
  input  logic              i_in_mode,
  input  logic              i_in_carry,
  output logic [WORD_W-1:0] o_alu_a,
  output logic [WORD_W-1:0] o_alu_b,
  output logic [3:0]        o_alu_select,
  output logic              o_alu_mode,
  output logic              o_alu_carry_in,
  input  logic [WORD_W-1:0] i_alu_out,
  input  logic              i_alu_carry,
  input  logic              i_alu_compare,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [OP_W-1:0]   o_out_result,
  output logic              o_out_carry,
  output logic              o_out_equal
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [OP_W-1:0]    r_a;
  logic [OP_W-1:0]    r_b;
  logic [3:0]         r_sel;
  logic               r_mode;
  logic               r_carry;
  logic               r_eq;
  logic [OP_W-1:0]    r_result;
  logic               w_last;
  logic               w_chain;
  logic               w_accept;

  assign w_last   = (r_idx == IDX_W'(NUM_WORDS - 1));
  assign w_accept = (r_state == S_IDLE) && i_in_valid;
  // Select 0011 in arithmetic mode yields no usable carry, so the chain is cut there too.
  assign w_chain  = (!r_mode && (r_sel != 4'b0011)) ? i_alu_carry : 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)      w_state_nxt = S_DONE;
      S_DONE:  if (i_out_ready) w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready     = (r_state == S_IDLE);
    o_out_valid    = (r_state == S_DONE);
    o_alu_a        = r_a[r_idx*WORD_W +: WORD_W];
    o_alu_b        = r_b[r_idx*WORD_W +: WORD_W];
    o_alu_select   = r_sel;
    o_alu_mode     = r_mode;
    o_alu_carry_in = r_mode ? 1'b0 : r_carry;
    o_out_result   = r_result;
    o_out_carry    = r_carry;
    o_out_equal    = r_eq;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sel    <= '0;
      r_mode   <= 1'b0;
      r_carry  <= 1'b0;
      r_eq     <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_idx    <= '0;
      r_a      <= i_in_a;
      r_b      <= i_in_b;
      r_sel    <= i_in_select;
      r_mode   <= i_in_mode;
      r_carry  <= i_in_mode ? 1'b0 : i_in_carry;
      r_eq     <= 1'b1;
    end else if (r_state == S_RUN) begin
      r_result[r_idx*WORD_W +: WORD_W] <= i_alu_out;
      r_eq     <= r_eq & i_alu_compare;
      r_carry  <= w_chain;
      r_idx    <= w_last ? '0 : r_idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// tb/tb_alu_mp_sequencer.sv - random and directed bench with a bench-side ALU and wide reference model
module tb_alu_mp_sequencer;
  localparam int W    = 16;
  localparam int N    = 4;
  localparam int OP_W = W * N;
  localparam int OPW1 = OP_W + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [OP_W-1:0] in_a = '0;
  logic [OP_W-1:0] in_b = '0;
  logic [3:0]      in_select = '0;
  logic            in_mode = 1'b0;
  logic            in_carry = 1'b0;
  logic [W-1:0]    alu_a, alu_b, alu_out;
  logic [3:0]      alu_select;
  logic            alu_mode, alu_carry_in, alu_carry, alu_compare;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [OP_W-1:0] out_result;
  logic            out_carry, out_equal;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_mp_sequencer #(.WORD_W(W), .NUM_WORDS(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_a(in_a), .i_in_b(in_b), .i_in_select(in_select), .i_in_mode(in_mode),
    .i_in_carry(in_carry), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_select(alu_select),
    .o_alu_mode(alu_mode), .o_alu_carry_in(alu_carry_in), .i_alu_out(alu_out),
    .i_alu_carry(alu_carry), .i_alu_compare(alu_compare), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_result(out_result), .o_out_carry(out_carry),
    .o_out_equal(out_equal)
  );

  // Combinational single-slice ALU; logic-mode carry is deliberately junk.
  always_comb begin
    logic [W:0] s;
    s = '0;
    alu_out = '0;
    alu_carry = 1'b0;
    if (alu_mode) begin
      case (alu_select)
        4'b0110: alu_out = alu_a ^ alu_b;
        4'b1011: alu_out = alu_a & alu_b;
        4'b1110: alu_out = alu_a | alu_b;
        default: alu_out = ~alu_a;
      endcase
      alu_carry = ^alu_a;
    end else begin
      case (alu_select)
        4'b1001: s = {1'b0, alu_a} + {1'b0, alu_b} + (W+1)'(alu_carry_in);
        4'b0010: s = {1'b0, alu_a} + {1'b0, ~alu_b} + (W+1)'(alu_carry_in);
        4'b0011: s = {1'b0, {W{1'b1}}} + (W+1)'(alu_carry_in);
        default: s = {1'b0, alu_a} + (W+1)'(alu_carry_in);
      endcase
      alu_out   = s[W-1:0];
      alu_carry = s[W];
    end
    alu_compare = (alu_a == alu_b);
  end

  function automatic logic [OP_W:0] wide(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                         input logic [3:0] sel, input logic mode, input logic cin);
    logic [OP_W-1:0] r;
    logic [W-1:0]    s0;
    if (mode) begin
      case (sel)
        4'b0110: r = a ^ b;
        4'b1011: r = a & b;
        4'b1110: r = a | b;
        default: r = ~a;
      endcase
      return {1'b0, r};
    end
    case (sel)
      4'b1001: return {1'b0, a} + {1'b0, b} + OPW1'(cin);
      4'b0010: return {1'b0, a} + {1'b0, ~b} + OPW1'(cin);
      4'b0011: begin
        s0 = {W{1'b1}} + W'(cin);
        r = {OP_W{1'b1}};
        r[W-1:0] = s0;
        return {1'b0, r};
      end
      default: return {1'b0, a} + OPW1'(cin);
    endcase
  endfunction

  task automatic chk(input string name, input logic [OP_W:0] act, input logic [OP_W:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: 0 idle, 1 busy (m_cnt slices left), 2 result held
  int              m_st = 0;
  int              m_cnt = 0;
  logic [OP_W-1:0] m_a, m_b;
  logic [3:0]      m_sel;
  logic            m_mode, m_cin, m_eq;
  logic [OP_W:0]   m_exp;
  bit              m_after_rst = 1'b0;

  always @(posedge clk) begin
    m_after_rst <= rst;
    if (rst) begin
      m_st  <= 0;
      m_cnt <= 0;
    end else begin
      case (m_st)
        0: if (in_valid) begin
          m_st   <= 1;
          m_cnt  <= N;
          m_a    <= in_a;
          m_b    <= in_b;
          m_sel  <= in_select;
          m_mode <= in_mode;
          m_cin  <= in_carry;
          m_eq   <= (in_a == in_b);
          m_exp  <= wide(in_a, in_b, in_select, in_mode, in_carry);
        end
        1: begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) m_st <= 2;
        end
        default: if (out_ready) m_st <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", OPW1'(in_ready), OPW1'(m_st == 0));
      chk("out_valid", OPW1'(out_valid), OPW1'(m_st == 2));
      if (m_st == 2) begin
        chk("out_result", OPW1'(out_result), OPW1'(m_exp[OP_W-1:0]));
        chk("out_carry", OPW1'(out_carry), OPW1'(m_exp[OP_W]));
        chk("out_equal", OPW1'(out_equal), OPW1'(m_eq));
      end
      if (m_st == 1) begin
        chk("alu_a", OPW1'(alu_a), OPW1'(W'(m_a >> ((N - m_cnt) * W))));
        chk("alu_b", OPW1'(alu_b), OPW1'(W'(m_b >> ((N - m_cnt) * W))));
        chk("alu_select", OPW1'(alu_select), OPW1'(m_sel));
        chk("alu_mode", OPW1'(alu_mode), OPW1'(m_mode));
        if (m_mode) chk("alu_cin_logic", OPW1'(alu_carry_in), '0);
        else if (m_cnt == N) chk("alu_cin_slice0", OPW1'(alu_carry_in), OPW1'(m_cin));
      end
      if (m_after_rst) begin
        chk("rst_result", OPW1'(out_result), '0);
        chk("rst_carry", OPW1'(out_carry), '0);
        chk("rst_equal", OPW1'(out_equal), '0);
      end
    end
  end

  task automatic run_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic [3:0] sel,
                        input logic mode, input logic cin, input int hold,
                        output logic [OP_W-1:0] res, output logic car, output logic eq,
                        output int lat);
    int n;
    @(posedge clk); #2;
    in_a = a; in_b = b; in_select = sel; in_mode = mode; in_carry = cin; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", '0, OPW1'(1));
    @(posedge clk); #2;
    lat = 0;
    forever begin
      in_valid = 1'($urandom_range(0, 1));
      in_a = {$urandom, $urandom};
      @(negedge clk);
      if (out_valid || lat > 20) break;
      lat++;
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    if (!out_valid) chk("done_timeout", '0, OPW1'(1));
    res = out_result;
    car = out_carry;
    eq  = out_equal;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_result", OPW1'(out_result), OPW1'(res));
      chk("hold_in_ready", OPW1'(in_ready), '0);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [OP_W-1:0] res, a, b;
    logic            car, eq;
    int              lat;
    logic [3:0]      sel;
    logic            mode;

    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", OPW1'(in_ready), OPW1'(1));
    chk("reset_out_valid", OPW1'(out_valid), '0);
    chk("reset_out_result", OPW1'(out_result), '0);

    run_op(64'h0000_0000_FFFF_FFFF, 64'd1, 4'b1001, 1'b0, 1'b0, 0, res, car, eq, lat);
    chk("add_result", OPW1'(res), OPW1'(64'h0000_0001_0000_0000));
    chk("add_carry", OPW1'(car), '0);
    chk("add_latency", OPW1'(lat), OPW1'(4));

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1001, 1'b0, 1'b0, 0, res, car, eq, lat);
    chk("wrap_result", OPW1'(res), '0);
    chk("wrap_carry", OPW1'(car), OPW1'(1));
    chk("wrap_equal", OPW1'(eq), '0);

    run_op(64'h0000_0000_0001_0000, 64'd1, 4'b0010, 1'b0, 1'b1, 0, res, car, eq, lat);
    chk("sub_result", OPW1'(res), OPW1'(64'h0000_0000_0000_FFFF));
    chk("sub_carry", OPW1'(car), OPW1'(1));

    run_op(64'd0, 64'd1, 4'b0010, 1'b0, 1'b1, 1, res, car, eq, lat);
    chk("borrow_result", OPW1'(res), OPW1'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("borrow_carry", OPW1'(car), '0);

    run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 4'b0110, 1'b1, 1'b1, 0,
           res, car, eq, lat);
    chk("xor_result", OPW1'(res), '0);
    chk("xor_carry", OPW1'(car), '0);
    chk("xor_equal", OPW1'(eq), OPW1'(1));

    run_op(64'h0000_0000_0000_0005, 64'd0, 4'b0011, 1'b0, 1'b1, 0, res, car, eq, lat);
    chk("sel3_result", OPW1'(res), OPW1'(64'hFFFF_FFFF_FFFF_0000));
    chk("sel3_carry", OPW1'(car), '0);

    run_op(64'h0000_0000_FFFF_FFFF, 64'd1, 4'b1001, 1'b0, 1'b0, 3, res, car, eq, lat);
    chk("bp_result", OPW1'(res), OPW1'(64'h0000_0001_0000_0000));

    // Abort an add in its second RUN cycle.
    @(posedge clk); #2;
    in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'd1; in_select = 4'b1001;
    in_mode = 1'b0; in_carry = 1'b0; in_valid = 1'b1;
    @(posedge clk); #2 in_valid = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", OPW1'(out_valid), '0);
    chk("abort_in_ready", OPW1'(in_ready), OPW1'(1));
    chk("abort_result", OPW1'(out_result), '0);
    repeat (8) @(negedge clk);
    chk("abort_no_valid", OPW1'(out_valid), '0);

    run_op(64'h0000_0000_FFFF_FFFF, 64'd1, 4'b1001, 1'b0, 1'b0, 0, res, car, eq, lat);
    chk("post_rst_result", OPW1'(res), OPW1'(64'h0000_0001_0000_0000));
    chk("post_rst_latency", OPW1'(lat), OPW1'(4));

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: a = '1;
        1: a = '0;
        default: a = {$urandom, $urandom};
      endcase
      b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      mode = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: sel = mode ? 4'b0110 : 4'b1001;
        1: sel = mode ? 4'b1011 : 4'b0010;
        2: sel = mode ? 4'b1110 : 4'b0011;
        default: sel = 4'b0000;
      endcase
      run_op(a, b, sel, mode, 1'($urandom_range(0, 1)), $urandom_range(0, 3), res, car, eq, lat);
      chk("rand_latency", OPW1'(lat), OPW1'(N));
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
